dma_region_monitor: RTL
=======================

DMA_REGION_MONITOR -- requirements
Module: dma_region_monitor

Interface
REQ-001 SHALL have parameter NREG, default 2, meaning number of protected regions (1..8).
REQ-002 SHALL have parameter REG_BASE, default {16'h0090,16'h0A00}, meaning packed 16-bit region base addresses, with region 0 in the LSBs.
REQ-003 SHALL have parameter REG_SIZE, default {16'h0010,16'h0100}, meaning packed 16-bit region sizes in bytes; size 0 disables the region.
REQ-004 SHALL have parameter REG_RD_OK, default 2'b10, meaning per-region DMA read permission bitmask.
REQ-005 SHALL have parameter REG_WR_OK, default 2'b00, meaning per-region DMA write permission bitmask.
REQ-006 SHALL have parameter RESET_HANDLER, default 16'h0000, meaning the PC value that permits release from kill.
REQ-007 SHALL have parameter HOLD_CYCLES, default 4, meaning the minimum number of cycles the reset output stays asserted after a violation (1..255).
REQ-008 clk  input  1  system clock; all state updates on the rising edge.
REQ-009 puc_rst  input  1  synchronous, active-high reset.
REQ-010 pc  input  16  current CPU program counter.
REQ-011 dma_addr  input  16  DMA byte address.
REQ-012 dma_en  input  1  DMA access valid this cycle.
REQ-013 dma_we  input  2  DMA byte write enables; nonzero means write, zero means read.
REQ-014 clr_log  input  1  single-cycle pulse that clears the violation log and counter.
REQ-015 reset  output  1  kill request to the CPU; registered.
REQ-016 viol  output  1  sticky flag: a violation has been logged.
REQ-017 viol_region  output  3  index of the first logged violating region.
REQ-018 viol_addr  output  16  dma_addr of the first logged violation.
REQ-019 viol_cnt  output  8  saturating count of violating cycles.

Function
REQ-020 Region i SHALL match when dma_en=1 and REG_BASE[i] <= dma_addr < REG_BASE[i]+REG_SIZE[i], with the sum computed in 17 bits so that the upper bound never wraps.
REQ-021 A region match SHALL be a violation when either (dma_we!=0 and REG_WR_OK[i]=0) or (dma_we==0 and REG_RD_OK[i]=0).
REQ-022 When regions overlap, a violation SHALL be raised if any matching region forbids the access, and the lowest-index forbidding region is the one reported.
REQ-023 The FSM SHALL have three states: RUN, KILL and WAIT.
REQ-024 From RUN, a violation SHALL cause a transition to KILL and load the hold counter with HOLD_CYCLES-1.
REQ-025 In KILL, a violation SHALL reload the hold counter; otherwise the counter decrements, and on reaching 0 the FSM transitions to WAIT.
REQ-026 In WAIT, a violation SHALL cause a transition to KILL with the hold counter reloaded.
REQ-027 In WAIT, pc==RESET_HANDLER with no violation in the same cycle SHALL cause a transition to RUN; otherwise the FSM stays in WAIT.
REQ-028 reset SHALL be registered and equal 1 whenever the state is not RUN; the violation-to-reset latency is exactly 1 cycle.
REQ-029 When a violation occurs and viol=0, the block SHALL capture viol_addr and viol_region and set viol; later violations do not overwrite the log.
REQ-030 viol_cnt SHALL increment on every violating cycle, in any state, and saturate at 8'hFF.
REQ-031 When clr_log=1, viol, viol_cnt, viol_addr and viol_region SHALL be cleared to 0; if a violation occurs in the same cycle, it is logged instead and viol_cnt becomes 1.
REQ-032 clr_log SHALL NOT affect the FSM or the reset output.

Reset
REQ-033 While puc_rst=1 the block SHALL hold state=KILL with the hold counter at HOLD_CYCLES-1, reset=1, and viol=0, viol_region=0, viol_addr=0, viol_cnt=0.
REQ-034 After puc_rst is released, the block SHALL follow the normal KILL->WAIT->RUN release path; puc_rst asserted mid-operation SHALL abort any state, including RUN and WAIT.

Verification
REQ-035 Scenario: release puc_rst with pc=0x0000 and no DMA -> reset=1 for 4 cycles (KILL), then reset=0 one cycle after WAIT is observed with pc=0x0000.
REQ-036 Scenario: in RUN, DMA read of 0x0A10 (region 0) -> reset=1 on the next cycle, viol=1, viol_region=0, viol_addr=0x0A10, viol_cnt=1.
REQ-037 Scenario: in RUN, DMA read of 0x0095 -> no violation and reset stays 0; DMA write of 0x0095 with dma_we=2'b01 -> violation with viol_region=1.
REQ-038 Scenario: boundary addresses 0x09FF and 0x0B00 -> no violation; 0x0A00 and 0x0AFF -> violation.
REQ-039 Scenario: violation at the 2nd KILL cycle -> the hold restarts, giving reset high for at least 4 cycles after the last violation; pc held at 0x0000 during WAIT alongside a violation -> stays in KILL.
REQ-040 Scenario: 300 consecutive violating cycles -> viol_cnt=0xFF; clr_log asserted together with a violation at 0x0A20 -> viol_cnt=1, viol_addr=0x0A20.

Source files
------------

// File: rtl/dma_region_monitor.sv
// dma_region_monitor
//   Watches DMA accesses against a set of protected address regions. A
//   forbidden access (read or write without permission) requests a CPU kill
//   through 'reset', held for at least HOLD_CYCLES cycles, then released once
//   the CPU program counter sits at RESET_HANDLER. The first violation is
//   logged (region, address) and every violating cycle is counted.
//
// Ports
//   clk          system clock, rising edge
//   puc_rst      synchronous active-high reset
//   pc           CPU program counter
//   dma_addr     DMA byte address
//   dma_en       DMA access valid
//   dma_we       DMA byte write enables (0 = read)
//   clr_log      clears the violation log and counter
//   reset        registered kill request
//   viol         sticky "violation logged" flag
//   viol_region  region index of the first logged violation
//   viol_addr    address of the first logged violation
//   viol_cnt     saturating count of violating cycles
//
// state | meaning
// RUN   | normal operation, reset low
// KILL  | reset held while the hold counter runs down
// WAIT  | hold expired, waiting for pc to reach RESET_HANDLER

module dma_region_monitor #(
  parameter int                    NREG          = 2,
  parameter logic [16*NREG-1:0]    REG_BASE      = {16'h0090, 16'h0A00},
  parameter logic [16*NREG-1:0]    REG_SIZE      = {16'h0010, 16'h0100},
  parameter logic [NREG-1:0]       REG_RD_OK     = 2'b10,
  parameter logic [NREG-1:0]       REG_WR_OK     = 2'b00,
  parameter logic [15:0]           RESET_HANDLER = 16'h0000,
  parameter int                    HOLD_CYCLES   = 4
) (
  input  logic        clk,
  input  logic        puc_rst,
  input  logic [15:0] pc,
  input  logic [15:0] dma_addr,
  input  logic        dma_en,
  input  logic [1:0]  dma_we,
  input  logic        clr_log,
  output logic        reset,
  output logic        viol,
  output logic [2:0]  viol_region,
  output logic [15:0] viol_addr,
  output logic [7:0]  viol_cnt
);

  typedef enum logic [1:0] {S_RUN, S_KILL, S_WAIT} state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  hold_cnt;
  logic [7:0]  hold_nxt;
  logic        reset_d;

  logic              is_wr;
  logic [NREG-1:0]   forbid;
  logic              viol_now;
  logic [2:0]        viol_idx;

  assign is_wr = (dma_we != 2'b00);

  // Bounds are compared in 17 bits so base+size never wraps; size 0 gives
  // an empty range and the region can never match.
  for (genvar g = 0; g < NREG; g++) begin : g_region
    localparam logic [16:0] LO = {1'b0, REG_BASE[16*g +: 16]};
    localparam logic [16:0] HI = LO + {1'b0, REG_SIZE[16*g +: 16]};
    assign forbid[g] = dma_en &&
                       ({1'b0, dma_addr} >= LO) &&
                       ({1'b0, dma_addr} <  HI) &&
                       (is_wr ? !REG_WR_OK[g] : !REG_RD_OK[g]);
  end

  assign viol_now = |forbid;

  // Scan downward so the lowest forbidding region wins.
  always_comb begin
    viol_idx = 3'd0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (forbid[i]) viol_idx = i[2:0];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (puc_rst) begin
      state    <= S_KILL;
      hold_cnt <= HOLD_LOAD;
      reset    <= 1'b1;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      reset    <= reset_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if (viol_now) state_nxt = S_KILL;
      S_KILL:  if (!viol_now && hold_cnt == 8'd0) state_nxt = S_WAIT;
      S_WAIT: begin
        if (viol_now)                 state_nxt = S_KILL;
        else if (pc == RESET_HANDLER) state_nxt = S_RUN;
      end
      default: state_nxt = S_KILL;
    endcase
  end

  // Output / datapath logic; reset is registered from the next state so it
  // rises exactly one cycle after the violating access.
  always_comb begin
    hold_nxt = hold_cnt;
    if (viol_now)
      hold_nxt = HOLD_LOAD;
    else if (state == S_KILL && hold_cnt != 8'd0)
      hold_nxt = hold_cnt - 8'd1;
    reset_d = (state_nxt != S_RUN);
  end

  // Violation log: a same-cycle violation overrides clr_log.
  always_ff @(posedge clk) begin
    if (puc_rst) begin
      viol        <= 1'b0;
      viol_region <= 3'd0;
      viol_addr   <= 16'h0000;
    end else if (viol_now && (!viol || clr_log)) begin
      viol        <= 1'b1;
      viol_region <= viol_idx;
      viol_addr   <= dma_addr;
    end else if (clr_log) begin
      viol        <= 1'b0;
      viol_region <= 3'd0;
      viol_addr   <= 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (puc_rst)
      viol_cnt <= 8'd0;
    else if (clr_log)
      viol_cnt <= viol_now ? 8'd1 : 8'd0;
    else if (viol_now && viol_cnt != 8'hFF)
      viol_cnt <= viol_cnt + 8'd1;
  end

endmodule
